// File: rtl/memory_bus_master.sv
// rtl/memory_bus_master.sv - single-byte initiator for the shared 4-bank SRAM bus
module memory_bus_master #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 8,
  parameter int READ_WAIT  = 1,
  parameter int TURNAROUND = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_write,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  read_enable,
  output logic                  write_enable,
  output logic [1:0]            chip_select,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_TURN  = 2'd3;

  localparam logic [3:0] WAIT_INIT = 4'(READ_WAIT);
  localparam logic [1:0] TURN_INIT = 2'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic [1:0]            turn_cnt;
  logic [DATA_WIDTH-1:0] wdata_q;

  assign req_ready = (state == S_IDLE) && !reset;

  // The bus is driven only during the WRITE cycle, so it can never collide with a read.
  assign data = write_enable ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      turn_cnt     <= '0;
      wdata_q      <= '0;
      address      <= '0;
      chip_select  <= '0;
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      resp_valid   <= 1'b0;
      resp_write   <= 1'b0;
      resp_rdata   <= '0;
      busy         <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            address     <= req_addr[ADDR_WIDTH-1:0];
            chip_select <= req_addr[ADDR_WIDTH+1:ADDR_WIDTH];
            busy        <= 1'b1;
            if (req_write) begin
              state        <= S_WRITE;
              write_enable <= 1'b1;
              wdata_q      <= req_wdata;
            end else begin
              state       <= S_READ;
              read_enable <= 1'b1;
              wait_cnt    <= WAIT_INIT;
            end
          end
        end
        S_WRITE: begin
          state        <= S_IDLE;
          write_enable <= 1'b0;
          busy         <= 1'b0;
          resp_valid   <= 1'b1;
          resp_write   <= 1'b1;
        end
        S_READ: begin
          if (wait_cnt == 4'd0) begin
            read_enable <= 1'b0;
            resp_rdata  <= data;
            resp_valid  <= 1'b1;
            resp_write  <= 1'b0;
            if (TURNAROUND > 0) begin
              state    <= S_TURN;
              turn_cnt <= TURN_INIT;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_TURN: begin
          if (turn_cnt == 2'd0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            turn_cnt <= turn_cnt - 2'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/memory_bus_master.md
# memory_bus_master

Initiator for the shared 4-bank SRAM memory bus. Accepts single-byte read/write requests from a core over a valid/ready handshake and drives the bus address, chip select, read/write strobes and the bidirectional data lines. It samples read data after a programmable number of wait cycles and returns a one-cycle response pulse. It sits between the core's load/store path and the `memory_bus` responder.

## Interface
- `ADDR_WIDTH`, 22: per-bank byte address width.
- `DATA_WIDTH`, 8: data bus width.
- `READ_WAIT`, 1: extra read cycles beyond the first; legal range 0–15.
- `TURNAROUND`, 1: idle bus cycles after a read before the next request is accepted; legal range 0–3.

Ports:
- `clk`  in  1: single clock, all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: block can accept a request.
- `req_write`  in  1: 1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH+2: [ADDR_WIDTH+1:ADDR_WIDTH] selects the bank; low bits are the byte address.
- `req_wdata`  in  DATA_WIDTH: write data.
- `resp_valid`  out  1: one-cycle completion pulse.
- `resp_write`  out  1: completed operation was a write.
- `resp_rdata`  out  DATA_WIDTH: read data, valid when `resp_valid & ~resp_write`.
- `address`  out  ADDR_WIDTH: bus address.
- `data`  inout  DATA_WIDTH: bus data. Driven only while `write_enable`=1, otherwise high-Z.
- `read_enable`  out  1: bus read strobe.
- `write_enable`  out  1: bus write strobe; the responder commits on the rising edge while it is high.
- `chip_select`  out  2: bank select.
- `busy`  out  1: state ≠ IDLE.

## Operation
- States: IDLE, WRITE, READ, TURN.
- `req_ready` = (state==IDLE) & ~`reset`. Handshake occurs on an edge where `req_valid & req_ready`. At that edge, `req_write`/`req_addr`/`req_wdata` are captured.
- IDLE→WRITE on a write handshake:
  - WRITE lasts exactly 1 cycle with `write_enable`=1 and `data` driven with the captured wdata.
  - Then IDLE, with `resp_valid`=1 and `resp_write`=1.
- IDLE→READ on a read handshake:
  - READ lasts READ_WAIT+1 cycles with `read_enable`=1 and `data` high-Z. A 4-bit counter loads READ_WAIT and decrements.
  - `data` is sampled into `resp_rdata` on the edge ending the last READ cycle.
  - Then TURN if TURNAROUND>0, else IDLE. `resp_valid`=1 and `resp_write`=0 in the following cycle.
- TURN lasts TURNAROUND cycles with both strobes 0, then IDLE.
- `address`/`chip_select` are loaded at handshake. They are held through the transaction and afterwards until the next handshake.
- Invariants:
  - `read_enable & write_enable` is never 1.
  - `data` is never driven while `read_enable`=1.
  - Strobes are 0 in IDLE.
- `resp_rdata` holds its value until the next read completes.
- `req_valid` while not ready: ignored. The request is not lost if the requester holds it; the block takes it on the first IDLE cycle.
- There is no response backpressure; the consumer must take `resp_valid` when it pulses.

## Timing
- All outputs are registered except `req_ready` and the `data` tri-state enable, which are decoded from registered state.
- Reset values: state IDLE; `address` 0; `chip_select` 0; `read_enable` 0; `write_enable` 0; `data` high-Z; `resp_valid` 0; `resp_write` 0; `resp_rdata` 0; `busy` 0. `req_ready` is 0 while `reset`=1.
- Write, with handshake at edge N:
  - WRITE in cycle N+1.
  - `resp_valid` and `req_ready` in cycle N+2.
  - Throughput is 1 write per 2 cycles.
- Read, with handshake at edge N:
  - `read_enable` in cycles N+1 … N+1+READ_WAIT.
  - `resp_valid` in cycle N+2+READ_WAIT.
  - `req_ready` in cycle N+2+READ_WAIT+TURNAROUND.
  - Default parameters: resp at N+3, ready at N+4.
- Reset mid-transaction:
  - Abort at the reset edge: strobes drop and `data` is released in the next cycle.
  - No `resp_valid` is produced for the aborted request.
  - A write whose WRITE cycle coincides with the reset edge may still be committed by the responder.

## Test plan
- Write 0xA5 to bank 2, addr 0x00_1234, then read the same location → `resp_rdata`=0xA5. `chip_select`=2'b10 during both. `resp_valid` pulses at N+2 for the write and N+3 for the read.
- Write a distinct byte to addr 0x3F_FFFF in each of the 4 banks, then read all four back → each bank returns its own byte, with no aliasing across banks.
- Hold `req_valid`=1 for 6 back-to-back writes → one WRITE every 2 cycles, `req_ready` toggles 1/0, and all 6 `resp_valid` pulses have `resp_write`=1.
- Set READ_WAIT=3, TURNAROUND=0 and read a preloaded 0x3C:
  - `read_enable` high for exactly 4 cycles, `resp_rdata`=0x3C.
  - `req_ready` returns in the same cycle as `resp_valid`.
- Assert `reset` during the 2nd READ cycle → strobes 0 the next cycle, no `resp_valid`, all outputs at reset values, and `req_ready`=1 the cycle after `reset` deasserts.
- Protocol monitor across random traffic:
  - `read_enable & write_enable` never both 1.
  - `data` never driven while `read_enable`=1.
  - `address`/`chip_select` stable throughout each transaction.
